// File: rtl/poisson_pkg.sv
// Shared types and defaults for the Poisson spike generator.
package poisson_pkg;

  localparam int RATE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rate_regfile.sv
// Per-neuron rate storage: one write port, combinational read of the neuron under evaluation.
module rate_regfile #(
  parameter int N_NEURONS = 16,
  parameter int RATE_W    = 16,
  parameter int ADDR_W    = $clog2(N_NEURONS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [RATE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [RATE_W-1:0] rdata
);

  localparam logic [ADDR_W:0] N_L = (ADDR_W+1)'(N_NEURONS);

  logic [N_NEURONS-1:0][RATE_W-1:0] mem_q, mem_d;
  logic                             wr_ok, rd_ok;

  // Indices past the array end exist when N_NEURONS is not a power of two.
  assign wr_ok = we && ({1'b0, waddr} < N_L);
  assign rd_ok = {1'b0, raddr} < N_L;

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_q <= '0;
    else          mem_q <= mem_d;
  end

  assign rdata = rd_ok ? mem_q[raddr] : '0;

endmodule

// File: rtl/poisson_spike_gen.sv
// Sweeps all neurons once per tick, comparing one fresh LFSR sample per neuron
// against its rate, and streams the indices of spiking neurons out as address-events.
module poisson_spike_gen
  import poisson_pkg::*;
#(
  parameter int N_NEURONS = 16,
  parameter int RATE_W    = RATE_W_DEF,
  parameter int ADDR_W    = $clog2(N_NEURONS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              rate_we,
  input  logic [ADDR_W-1:0] rate_addr,
  input  logic [RATE_W-1:0] rate_data,
  input  logic [RATE_W-1:0] lfsr_in,
  output logic              lfsr_en,
  output logic              spk_valid,
  input  logic              spk_ready,
  output logic [ADDR_W-1:0] spk_addr,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                spk_valid_q, spk_valid_d;
  logic [ADDR_W-1:0]   spk_addr_q, spk_addr_d;
  logic                overrun_q, overrun_d;

  logic [RATE_W-1:0]   rate_rd;
  logic                out_free;
  logic                eval;
  logic                hit;

  rate_regfile #(
    .N_NEURONS (N_NEURONS),
    .RATE_W    (RATE_W),
    .ADDR_W    (ADDR_W)
  ) u_rates (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (rate_we),
    .waddr   (rate_addr),
    .wdata   (rate_data),
    .raddr   (idx_q),
    .rdata   (rate_rd)
  );

  // A neuron may only be evaluated when its possible spike has somewhere to go;
  // otherwise the sweep and the LFSR both stall.
  assign out_free = !spk_valid_q || spk_ready;
  assign eval     = (state_q == SCAN) && out_free;
  assign hit      = lfsr_in < rate_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (eval) begin
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!spk_valid_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    lfsr_en = eval;
    busy    = (state_q != IDLE);
    done    = (state_q == DRAIN) && !spk_valid_q;
  end

  // A reload in the same cycle as a handshake wins over the clear.
  always_comb begin
    spk_valid_d = spk_valid_q && !spk_ready;
    spk_addr_d  = spk_addr_q;
    if (eval && hit) begin
      spk_valid_d = 1'b1;
      spk_addr_d  = idx_q;
    end
    overrun_d = overrun_q || (tick && (state_q != IDLE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      spk_valid_q <= 1'b0;
      spk_addr_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      spk_valid_q <= spk_valid_d;
      spk_addr_q  <= spk_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spk_valid = spk_valid_q;
  assign spk_addr  = spk_addr_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_poisson_spike_gen.sv
// Scoreboard bench: each sweep's expected events come from a per-neuron Bernoulli model
// fed by the bench's own LFSR sequence; a negedge monitor consumes them on handshakes.
module tb_poisson_spike_gen;

  localparam int N  = 16;
  localparam int RW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          rate_we = 1'b0;
  logic [AW-1:0] rate_addr = '0;
  logic [RW-1:0] rate_data = '0;
  logic [RW-1:0] lfsr_q = 16'h0001;
  logic          lfsr_en;
  logic          spk_valid;
  logic          spk_ready = 1'b1;
  logic [AW-1:0] spk_addr;
  logic          busy, done, overrun;

  int            checks = 0;
  int            failures = 0;
  int            exp_q[$];
  int            rate_m[N];
  logic [RW-1:0] lfsr_pred;
  logic          seed_req = 1'b0;
  logic [RW-1:0] seed_val = '0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  poisson_spike_gen #(.N_NEURONS(N), .RATE_W(RW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .rate_we   (rate_we),
    .rate_addr (rate_addr),
    .rate_data (rate_data),
    .lfsr_in   (lfsr_q),
    .lfsr_en   (lfsr_en),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_addr  (spk_addr),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] lfsr_step(input logic [RW-1:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Stand-in for the upstream LFSR: advances on lfsr_en at the same edge.
  always @(posedge clk) begin
    if (seed_req)     lfsr_q <= seed_val;
    else if (lfsr_en) lfsr_q <= lfsr_step(lfsr_q);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: pops on handshakes, checks stall behaviour.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(spk_valid), 32'd1);
        chk("stall_addr_hold", 32'(spk_addr), 32'(prev_addr));
      end
      if (spk_valid && !spk_ready) begin
        chk("stall_lfsr_en", 32'(lfsr_en), 32'd0);
        prev_stall = 1'b1;
        prev_addr  = spk_addr;
      end else begin
        prev_stall = 1'b0;
      end
      if (spk_valid && spk_ready) begin
        if (exp_q.size() == 0) chk("spk_unexpected", 32'(spk_addr), 32'hFFFF_FFFF);
        else                   chk("spk_addr", 32'(spk_addr), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic seed(input logic [RW-1:0] v);
    seed_val = v;
    seed_req = 1'b1;
    @(posedge clk); #1;
    seed_req = 1'b0;
  endtask

  task automatic write_rate(input int a, input int d);
    rate_we   = 1'b1;
    rate_addr = AW'(a);
    rate_data = RW'(d);
    @(posedge clk); #1;
    rate_we   = 1'b0;
    rate_m[a] = d;
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 ready random.
  // t1/t2: cycles with an extra tick; wc: cycle carrying a write wa<=wd (-1 = none).
  task automatic run_sweep(input int mode, input int t1, input int t2,
                           input int wc, input int wa, input int wd, input string tag);
    logic [RW-1:0] s;
    int            cyc, en_cnt, exp_done;
    bit            got, last_hit;
    s = lfsr_q;
    last_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(s) < rate_m[i]) begin
        exp_q.push_back(i);
        if (i == N - 1) last_hit = 1'b1;
      end
      s = lfsr_step(s);
    end
    lfsr_pred = s;
    exp_done  = N + 1 + int'(last_hit);
    tick   = 1'b1;
    cyc    = 0;
    en_cnt = 0;
    got    = 1'b0;
    while (!got && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      tick = (cyc == t1) || (cyc == t2);
      if (cyc == wc) begin
        rate_we   = 1'b1;
        rate_addr = AW'(wa);
        rate_data = RW'(wd);
        rate_m[wa] = wd;
      end else begin
        rate_we = 1'b0;
      end
      case (mode)
        0:       spk_ready = 1'b1;
        1:       spk_ready = cyc[0];
        default: spk_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (lfsr_en) en_cnt++;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (mode == 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
    chk({tag, "_lfsr_en_count"}, 32'(en_cnt), 32'(N));
    chk({tag, "_events_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_lfsr_state"}, 32'(lfsr_q), 32'(lfsr_pred));
    @(posedge clk); #1;
    tick = 1'b0;
    rate_we = 1'b0;
    spk_ready = 1'b1;
    #1;
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_single_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) rate_m[i] = 0;
    #1;
    chk("rst_spk_valid", 32'(spk_valid), 32'd0);
    chk("rst_spk_addr", 32'(spk_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lfsr_en", 32'(lfsr_en), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seed(16'h0001);

    run_sweep(0, -1, -1, -1, 0, 0, "zero_rates");

    seed(16'h0001);
    for (int i = 0; i < N; i++) write_rate(i, 16'hFFFF);
    run_sweep(0, -1, -1, -1, 0, 0, "full_rates");

    for (int i = 0; i < N; i++) write_rate(i, (i % 2 == 0) ? 16'h8000 : 0);
    run_sweep(1, -1, -1, -1, 0, 0, "half_even");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) write_rate(i, int'($urandom_range(0, 65535)));
      run_sweep(2, -1, -1, -1, 0, 0, "random");
    end

    for (int i = 0; i < N; i++) write_rate(i, 0);
    run_sweep(0, -1, -1, 6, 5, 16'hFFFF, "late_write");
    run_sweep(0, -1, -1, -1, 0, 0, "after_write");

    for (int i = 0; i < N; i++) write_rate(i, 0);
    chk("overrun_before", 32'(overrun), 32'd0);
    run_sweep(0, 3, 17, -1, 0, 0, "overrun");
    chk("overrun_set", 32'(overrun), 32'd1);
    run_sweep(0, -1, -1, -1, 0, 0, "overrun_sticky");
    chk("overrun_held", 32'(overrun), 32'd1);

    seed(16'h0001);
    for (int i = 0; i < N; i++) write_rate(i, 16'hFFFF);
    spk_ready = 1'b0;
    tick = 1'b1;
    exp_q.push_back(0);
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_valid", 32'(spk_valid), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("arst_spk_valid", 32'(spk_valid), 32'd0);
    chk("arst_spk_addr", 32'(spk_addr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_lfsr_en", 32'(lfsr_en), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) rate_m[i] = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    spk_ready = 1'b1;
    write_rate(0, 16'hFFFF);
    write_rate(3, 16'hFFFF);
    run_sweep(0, -1, -1, -1, 0, 0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poisson_spike_gen.md
# poisson_spike_gen

Time-multiplexed Poisson spike generator for an array of `N_NEURONS` input neurons. It sits directly downstream of the 16-bit LFSR and drives the LFSR's `en` input. Once per timestep it sweeps all neurons, compares one fresh LFSR sample per neuron against that neuron's programmed rate, and emits the index of every spiking neuron as an address-event on a valid/ready stream.

## Interface
Parameters:
- `N_NEURONS`, 16: number of neurons in the array, ≥2.
- `RATE_W`, 16: rate and random-sample width; must equal the LFSR width.
- `ADDR_W`, `$clog2(N_NEURONS)`: neuron index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  timestep strobe, one cycle; starts a sweep.
- `rate_we`  in  1  rate write enable.
- `rate_addr`  in  `ADDR_W`  neuron index to write.
- `rate_data`  in  `RATE_W`  new rate; spike probability per timestep is `rate/2^RATE_W`.
- `lfsr_in`  in  `RATE_W`  current LFSR output (`lfsr_out`).
- `lfsr_en`  out  1  advance request to the LFSR.
- `spk_valid`  out  1  spike event present.
- `spk_ready`  in  1  consumer accepts the event.
- `spk_addr`  out  `ADDR_W`  index of the spiking neuron.
- `busy`  out  1  sweep in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse at sweep completion.
- `overrun`  out  1  sticky: `tick` arrived while busy.

## Operation
- Rate register file: `N_NEURONS`×`RATE_W`, reset to 0.
  - Writable in any cycle.
  - Out-of-range `rate_addr` writes are ignored.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE:
  - `tick`=1 → SCAN with `idx`=0.
  - Otherwise stay in IDLE.
- SCAN, per cycle:
  - The neuron is evaluated only if the output register is free (`!spk_valid`, or `spk_valid&&spk_ready` this cycle).
  - On evaluation:
    - hit = `lfsr_in < rate[idx]`, unsigned.
    - `lfsr_en`=1.
    - `idx` increments.
    - On a hit, the output register loads `spk_addr`=`idx` and `spk_valid`=1.
    - After evaluating `idx`=`N_NEURONS`-1 → DRAIN.
  - Not free (stall):
    - `lfsr_en`=0; `idx` and the LFSR hold.
- DRAIN:
  - When `spk_valid`=0: `done`=1 combinationally, then → IDLE next edge.
- Output register clears on `spk_valid&&spk_ready` unless reloaded that same cycle.
- `spk_valid` never drops and `spk_addr` never changes without a handshake.
- Exactly one LFSR advance per evaluated neuron. No advances occur in IDLE or DRAIN, or while stalled.
- Boundary conditions:
  - rate=0: the neuron never spikes.
  - rate=2^RATE_W−1: the neuron spikes unless the sample is all ones.
  - Write to `rate[idx]` in the same cycle that `idx` is evaluated: the comparison uses the old value, and the new value applies from the next sweep.
  - `tick` in SCAN or DRAIN: ignored, `overrun`←1. `overrun` clears only on reset.
  - `tick` in the same cycle that DRAIN completes: ignored, sets `overrun`.
- Reset mid-sweep aborts the sweep immediately. Nothing resumes after reset.

## Timing
- Reset values: state IDLE, `idx`=0, `spk_valid`=0, `spk_addr`=0, `lfsr_en`=0, `busy`=0, `done`=0, `overrun`=0, all rates 0.
- `tick` sampled at edge E0 → SCAN evaluates neuron 0 in the next cycle (C1).
- A spike found in cycle Ck is visible on `spk_valid` in Ck+1.
- With `spk_ready` tied high and no stalls:
  - Neurons are evaluated in C1..CN.
  - DRAIN is in CN+1.
  - `done` fires in CN+1 if neuron N−1 did not spike, else in CN+2.
- `lfsr_in` must reflect the advance from the previous cycle. The LFSR responds to `lfsr_en` at the same edge, so there is zero pipeline skew.
- All outputs except `done` and `lfsr_en` are registered. `done` and `lfsr_en` are combinational from state and handshake.

## Structure
- Package `poisson_pkg` holds:
  - `state_t` enum {IDLE, SCAN, DRAIN}.
  - Default `RATE_W`=16.
- Sub-module `rate_regfile`:
  - One write port; combinational read on `idx`.
  - Asynchronous active-low reset to 0.
- The LFSR remains a separate instance at the parent level, wired `en`←`lfsr_en` and `lfsr_in`←`lfsr_out`.

## Test plan
- Reset with all rates 0, `tick`, `spk_ready`=1 → no `spk_valid`; `done` in C17 (N=16); exactly 16 `lfsr_en` cycles.
- All rates 0xFFFF, LFSR model seeded 1, `spk_ready`=1 → addresses 0..15 emitted in order; `done` in C18.
- Rates {0x8000 even, 0 odd}, `spk_ready` toggling 1/0 → event list matches the reference model; stalls show `lfsr_en`=0 and `spk_addr` stable.
- `tick` during SCAN, then again during DRAIN → `overrun`=1 and stays 1; the sweep completes normally with one `done`.
- Write rate[5]=0xFFFF in the cycle neuron 5 is evaluated (old rate 0) → no spike for 5 this sweep; spike for 5 next sweep.
- Deassert `reset_n` mid-SCAN with `spk_valid`=1 → all outputs return to reset values asynchronously; the next `tick` starts at neuron 0.
